// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request handshake and IMEM write bus for instr_encoder
interface instr_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_rd;
  logic [4:0]        req_shamt;
  logic [5:0]        req_funct;
  logic [15:0]       req_imm;
  logic [25:0]       req_target;
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // Environment side: issues requests and plays the instruction memory.
  modport master (
    output req_valid, req_op, req_rs, req_rt, req_rd, req_shamt,
           req_funct, req_imm, req_target, imem_ready,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  // Encoder side.
  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_rd, req_shamt,
           req_funct, req_imm, req_target, imem_ready,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - encodes symbolic MIPS requests and streams them into IMEM
// Optional ENCODER_DELAY_SLOT_EN: a NOP is auto-written after every beq/j/jal.
module instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEPTH     = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       finish,
  instr_encoder_if.slave             bus,
  output logic [$clog2(DEPTH+1)-1:0] wr_count,
  output logic                       full,
  output logic                       err,
  output logic                       done
);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] alloc_count;
  logic [CW:0]   alloc_sum;
  logic [1:0]    need;
  logic          is_branch;
  logic          op_illegal;
  logic          nop_pending;
  logic          slot_is_nop;
  logic          we;
  logic [31:0]   wdata;
  logic [31:0]   enc;
  logic          ready_c;
  logic          accept;
  logic          wr_done;
  logic          slot_free;

`ifdef ENCODER_DELAY_SLOT_EN
  assign is_branch = (bus.req_op == 3'd2) || (bus.req_op == 3'd4) || (bus.req_op == 3'd5);
`else
  assign is_branch = 1'b0;
`endif

  assign op_illegal = (bus.req_op == 3'd7);
  assign need       = is_branch ? 2'd2 : 2'd1;
  assign alloc_sum  = {1'b0, alloc_count} + (CW+1)'(need);
  assign slot_free  = !we || bus.imem_ready;
  assign accept     = bus.req_valid && ready_c;
  assign wr_done    = we && bus.imem_ready;

  always_comb begin
    enc = 32'h0;
    case (bus.req_op)
      3'd0:    enc = {6'b100011, bus.req_rs, bus.req_rt, bus.req_imm};
      3'd1:    enc = {6'b101011, bus.req_rs, bus.req_rt, bus.req_imm};
      3'd2:    enc = {6'b000100, bus.req_rs, bus.req_rt, bus.req_imm};
      3'd3:    enc = {6'b000000, bus.req_rs, bus.req_rt, bus.req_rd,
                      bus.req_shamt, bus.req_funct};
      3'd4:    enc = {6'b000010, bus.req_target};
      3'd5:    enc = {6'b000011, bus.req_target};
      3'd6:    enc = {6'b001000, bus.req_rs, bus.req_rt, bus.req_imm};
      default: enc = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready_c  = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN: begin
        ready_c = slot_free && !nop_pending && (alloc_sum <= (CW+1)'(DEPTH));
        if (finish) state_nx = S_DRAIN;
      end
      S_DRAIN: if (!we && !nop_pending) state_nx = S_DONE;
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we          <= 1'b0;
      wdata       <= 32'h0;
      wr_count    <= '0;
      alloc_count <= '0;
      err         <= 1'b0;
      nop_pending <= 1'b0;
      slot_is_nop <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        wr_count    <= '0;
        alloc_count <= '0;
        err         <= 1'b0;
      end
      if (wr_done) wr_count <= wr_count + CW'(1);
      if (accept) begin
        if (op_illegal) err <= 1'b1;
        else            alloc_count <= alloc_count + CW'(need);
      end
      // A pending delay-slot NOP takes the slot right behind its branch;
      // new requests cannot arrive meanwhile since nop_pending blocks ready.
      if (wr_done && slot_is_nop) begin
        we          <= 1'b0;
        nop_pending <= 1'b0;
        slot_is_nop <= 1'b0;
      end else if (wr_done && nop_pending) begin
        we          <= 1'b1;
        wdata       <= 32'h0;
        slot_is_nop <= 1'b1;
      end else if (accept && !op_illegal) begin
        we          <= 1'b1;
        wdata       <= enc;
        nop_pending <= is_branch;
      end else if (wr_done) begin
        we <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.imem_we    = we;
  assign bus.imem_wdata = wdata;
  assign bus.imem_addr  = BASE_ADDR + ADDR_W'({wr_count, 2'b00});
  assign full           = (alloc_count == CW'(DEPTH));
endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;
`ifdef ENCODER_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic st0 = 0, st1 = 0, fin0 = 0, fin1 = 0, v0 = 0, v1 = 0, rdy0 = 1, rdy1 = 1;
  logic [2:0]  r_op = '0;
  logic [4:0]  r_rs = '0, r_rt = '0, r_rd = '0, r_sh = '0;
  logic [5:0]  r_fn = '0;
  logic [15:0] r_imm = '0;
  logic [25:0] r_tgt = '0;
  bit rmode = 1'b0;

  instr_encoder_if #(.ADDR_W(32)) b0 ();
  instr_encoder_if #(.ADDR_W(32)) b1 ();

  assign b0.req_valid = v0;   assign b1.req_valid = v1;
  assign b0.req_op = r_op;    assign b1.req_op = r_op;
  assign b0.req_rs = r_rs;    assign b1.req_rs = r_rs;
  assign b0.req_rt = r_rt;    assign b1.req_rt = r_rt;
  assign b0.req_rd = r_rd;    assign b1.req_rd = r_rd;
  assign b0.req_shamt = r_sh; assign b1.req_shamt = r_sh;
  assign b0.req_funct = r_fn; assign b1.req_funct = r_fn;
  assign b0.req_imm = r_imm;  assign b1.req_imm = r_imm;
  assign b0.req_target = r_tgt; assign b1.req_target = r_tgt;
  assign b0.imem_ready = rdy0;  assign b1.imem_ready = rdy1;

  logic [8:0] wc0;
  logic [2:0] wc1;
  logic full0, err0, done0, full1, err1, done1;

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(256)) u0 (
    .clk(clk), .reset(reset), .start(st0), .finish(fin0), .bus(b0),
    .wr_count(wc0), .full(full0), .err(err0), .done(done0));

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(4)) u1 (
    .clk(clk), .reset(reset), .start(st1), .finish(fin1), .bus(b1),
    .wr_count(wc1), .full(full1), .err(err1), .done(done1));

  logic [31:0] oa0[$], od0[$], oa1[$], od1[$], ea[$], ed[$];
  bit exp_err;
  int passed = 0, total = 0, failed = 0;

  // Memory model: records every completed write.
  always @(negedge clk) begin
    if (!reset) begin
      if (b0.imem_we && b0.imem_ready) begin oa0.push_back(b0.imem_addr); od0.push_back(b0.imem_wdata); end
      if (b1.imem_we && b1.imem_ready) begin oa1.push_back(b1.imem_addr); od1.push_back(b1.imem_wdata); end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rmode) rdy0 = ($urandom % 4) != 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_enc(input logic [2:0] op, input logic [4:0] rs, rt, rd, sh,
                                            input logic [5:0] fn, input logic [15:0] imm,
                                            input logic [25:0] tgt);
    longint w, opc;
    case (op)
      3'd0: opc = 35;  3'd1: opc = 43;  3'd2: opc = 4;
      3'd4: opc = 2;   3'd5: opc = 3;   3'd6: opc = 8;
      default: opc = 0;
    endcase
    if (op == 3'd3)
      w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048
        + longint'(sh) * 64 + longint'(fn);
    else if (op == 3'd4 || op == 3'd5)
      w = opc * 67108864 + longint'(tgt);
    else
      w = opc * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
    return w[31:0];
  endfunction

  task automatic model_push(input logic [31:0] word);
    ea.push_back(32'(4 * ea.size()));
    ed.push_back(word);
  endtask

  task automatic send(input int d, input logic [2:0] op, input logic [4:0] rs, rt, rd, sh,
                      input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt,
                      input bit with_fin);
    int n = 0;
    bit ok = 0;
    r_op = op; r_rs = rs; r_rt = rt; r_rd = rd; r_sh = sh; r_fn = fn; r_imm = imm; r_tgt = tgt;
    if (d == 0) begin v0 = 1; fin0 = with_fin; end
    else        begin v1 = 1; fin1 = with_fin; end
    while (!ok && n < 200) begin
      @(negedge clk);
      if ((d == 0) ? b0.req_ready : b1.req_ready) ok = 1;
      @(posedge clk); #1;
      n++;
    end
    v0 = 0; v1 = 0; fin0 = 0; fin1 = 0;
    check("accept", 64'(ok), 64'(1));
    if (ok) begin
      if (op == 3'd7) exp_err = 1;
      else begin
        model_push(model_enc(op, rs, rt, rd, sh, fn, imm, tgt));
        if (DS && (op == 3'd2 || op == 3'd4 || op == 3'd5)) model_push(32'h0);
      end
    end
  endtask

  task automatic begin_session(input int d);
    oa0.delete(); od0.delete(); oa1.delete(); od1.delete(); ea.delete(); ed.delete();
    exp_err = 0;
    @(posedge clk); #1;
    if (d == 0) st0 = 1; else st1 = 1;
    @(posedge clk); #1;
    st0 = 0; st1 = 0;
    @(negedge clk);
    check("start_err_clr", 64'((d == 0) ? err0 : err1), 64'(0));
    check("start_wc_clr", (d == 0) ? 64'(wc0) : 64'(wc1), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_finish(input int d);
    if (d == 0) fin0 = 1; else fin1 = 1;
    @(posedge clk); #1;
    fin0 = 0; fin1 = 0;
  endtask

  task automatic wait_done(input int d);
    int n = 0;
    bit got = 0;
    logic [31:0] qa[$], qd[$];
    while (!got && n < 500) begin
      @(negedge clk);
      if ((d == 0) ? done0 : done1) got = 1;
      n++;
    end
    check("done_seen", 64'(got), 64'(1));
    check("wr_count", (d == 0) ? 64'(wc0) : 64'(wc1), 64'(ed.size()));
    check("err", 64'((d == 0) ? err0 : err1), 64'(exp_err));
    @(negedge clk);
    check("done_pulse", 64'((d == 0) ? done0 : done1), 64'(0));
    if (d == 0) begin qa = oa0; qd = od0; end
    else        begin qa = oa1; qd = od1; end
    check("write_cnt", 64'(qa.size()), 64'(ea.size()));
    for (int i = 0; i < qa.size() && i < ea.size(); i++) begin
      check($sformatf("addr[%0d]", i), 64'(qa[i]), 64'(ea[i]));
      check($sformatf("data[%0d]", i), 64'(qd[i]), 64'(ed[i]));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] h_addr, h_data;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(b0.req_ready), 64'(0));
    check("rst_we", 64'(b0.imem_we), 64'(0));
    check("rst_addr", 64'(b0.imem_addr), 64'(0));
    check("rst_wdata", 64'(b0.imem_wdata), 64'(0));
    check("rst_wc", 64'(wc0), 64'(0));
    check("rst_full", 64'(full0), 64'(0));
    check("rst_err", 64'(err0), 64'(0));
    check("rst_done", 64'(done0), 64'(0));
    @(posedge clk); #1;
    reset = 0;

    // Basic encoding of every opcode
    begin_session(0);
    send(0, 3'd6, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 0);
    send(0, 3'd0, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0, 0);
    send(0, 3'd1, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'd8, 26'd0, 0);
    send(0, 3'd3, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'd0, 26'd0, 0);
    send(0, 3'd2, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 0);
    send(0, 3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 0);
    send(0, 3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 0);
    do_finish(0);
    wait_done(0);

    // Backpressure on the first write
    begin_session(0);
    rdy0 = 0;
    send(0, 3'd6, 5'd3, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 0);
    @(negedge clk);
    h_addr = b0.imem_addr;
    h_data = b0.imem_wdata;
    check("bp_we", 64'(b0.imem_we), 64'(1));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_we_hold", 64'(b0.imem_we), 64'(1));
      check("bp_addr_hold", 64'(b0.imem_addr), 64'(h_addr));
      check("bp_data_hold", 64'(b0.imem_wdata), 64'(h_data));
      check("bp_ready", 64'(b0.req_ready), 64'(0));
    end
    @(posedge clk); #1;
    rdy0 = 1;
    send(0, 3'd6, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'h0042, 26'd0, 0);
    do_finish(0);
    wait_done(0);

    // Illegal op between two addi; last request carries finish
    begin_session(0);
    send(0, 3'd6, 5'd0, 5'd4, 5'd0, 5'd0, 6'd0, 16'd1, 26'd0, 0);
    send(0, 3'd7, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'd6, 26'd7, 0);
    send(0, 3'd6, 5'd0, 5'd5, 5'd0, 5'd0, 6'd0, 16'd2, 26'd0, 1);
    wait_done(0);

    // Randomized requests under random memory backpressure
    begin_session(0);
    rmode = 1;
    for (int i = 0; i < 40; i++)
      send(0, 3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom), 0);
    rmode = 0;
    @(posedge clk); #1;
    rdy0 = 1;
    do_finish(0);
    wait_done(0);

    // Full at DEPTH=4: fifth request stalls
    begin_session(1);
    for (int i = 0; i < 4; i++)
      send(1, 3'd6, 5'd0, 5'(i + 1), 5'd0, 5'd0, 6'd0, 16'($urandom), 26'd0, 0);
    r_op = 3'd6; v1 = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("full_stall", 64'(b1.req_ready), 64'(0));
      @(posedge clk); #1;
    end
    v1 = 0;
    check("full_flag", 64'(full1), 64'(1));
    do_finish(1);
    wait_done(1);

`ifdef ENCODER_DELAY_SLOT_EN
    // Branch needing two slots with only one free stalls
    begin_session(1);
    for (int i = 0; i < 3; i++)
      send(1, 3'd6, 5'd0, 5'(i + 1), 5'd0, 5'd0, 6'd0, 16'(i), 26'd0, 0);
    r_op = 3'd2; v1 = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ds_branch_stall", 64'(b1.req_ready), 64'(0));
      @(posedge clk); #1;
    end
    v1 = 0;
    check("ds_not_full", 64'(full1), 64'(0));
    do_finish(1);
    wait_done(1);

    // Jump followed by automatic NOP
    begin_session(0);
    send(0, 3'd4, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h20, 0);
    send(0, 3'd6, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 0);
    do_finish(0);
    wait_done(0);
`endif

    // Reset while a write is pending
    begin_session(0);
    rdy0 = 0;
    send(0, 3'd6, 5'd0, 5'd7, 5'd0, 5'd0, 6'd0, 16'h77, 26'd0, 0);
    @(negedge clk);
    check("mid_we", 64'(b0.imem_we), 64'(1));
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mrst_we", 64'(b0.imem_we), 64'(0));
    check("mrst_wc", 64'(wc0), 64'(0));
    check("mrst_ready", 64'(b0.req_ready), 64'(0));
    check("mrst_addr", 64'(b0.imem_addr), 64'(0));
    check("mrst_wdata", 64'(b0.imem_wdata), 64'(0));
    @(posedge clk); #1;
    reset = 0;
    rdy0 = 1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mrst_no_writes", 64'(oa0.size()), 64'(0));
    check("mrst_idle_we", 64'(b0.imem_we), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
